// File: rtl/usb_rx_bit_decoder_if.sv
// usb_rx_bit_decoder_if
//   Groups the line inputs and the decoded-bit outputs of the USB full-speed
//   receive bit decoder.
//   master : drives the line (d_plus, d_minus), observes the decoded stream
//   slave  : the decoder itself
//   d_plus, d_minus : synchronized line levels
//   d_orig          : decoded data bit, valid with shift_enable
//   shift_enable    : one-cycle pulse per non-stuffed decoded bit
//   eop             : one-cycle pulse on a valid end-of-packet
//   stuff_error     : one-cycle pulse when a stuffed 0 was missing
//   line_error      : one-cycle pulse on a malformed SE0
//   rcving          : high while a packet is being received
interface usb_rx_bit_decoder_if;
  logic d_plus;
  logic d_minus;
  logic d_orig;
  logic shift_enable;
  logic eop;
  logic stuff_error;
  logic line_error;
  logic rcving;

  modport master (
    output d_plus, d_minus,
    input  d_orig, shift_enable, eop, stuff_error, line_error, rcving
  );

  modport slave (
    input  d_plus, d_minus,
    output d_orig, shift_enable, eop, stuff_error, line_error, rcving
  );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder
//   Full-speed USB receive front end: oversampled bit-timing recovery that
//   resynchronizes on every D+ transition, NRZI decode, bit-unstuffing and
//   SE0/EOP detection.
//   clk   : system clock, CLKS_PER_BIT x bit rate
//   n_rst : asynchronous active-low reset
//   bus   : slave side of usb_rx_bit_decoder_if (line in, decoded stream out)
//
//   state  | meaning
//   IDLE   | waiting for the first J->K transition of a packet
//   ACTIVE | decoding data bits
//   SE0_1  | one SE0 bit seen
//   SE0_2  | two or more SE0 bits seen, waiting for the closing J
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3,
  parameter int MAX_ONES     = 6
) (
  input logic clk,
  input logic n_rst,
  usb_rx_bit_decoder_if.slave bus
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int ONES_W = $clog2(MAX_ONES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_PT);
  localparam logic [ONES_W-1:0] ONES_MAX   = ONES_W'(MAX_ONES);

  typedef enum logic [1:0] {IDLE, ACTIVE, SE0_1, SE0_2} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ONES_W-1:0] ones, ones_n;
  logic              prev_dp, prev_dp_n;
  logic              dp_q;
  logic              d_orig_q, d_orig_n;
  logic              shift_q, shift_n;
  logic              eop_q, eop_n;
  logic              stuff_q, stuff_n;
  logic              line_q, line_n;
  logic              rcving_q;

  logic edge_det;
  logic line_se0;
  logic line_k;
  logic strobe;
  logic bit_val;

  // (1,1) falls through both tests below and is therefore handled as J.
  assign edge_det = bus.d_plus != dp_q;
  assign line_se0 = !bus.d_plus && !bus.d_minus;
  assign line_k   = !bus.d_plus &&  bus.d_minus;
  assign strobe   = (cnt == CNT_SAMPLE) && !edge_det;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ones     <= '0;
      prev_dp  <= 1'b1;
      dp_q     <= 1'b1;
      d_orig_q <= 1'b0;
      shift_q  <= 1'b0;
      eop_q    <= 1'b0;
      stuff_q  <= 1'b0;
      line_q   <= 1'b0;
      rcving_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ones     <= ones_n;
      prev_dp  <= prev_dp_n;
      dp_q     <= bus.d_plus;
      d_orig_q <= d_orig_n;
      shift_q  <= shift_n;
      eop_q    <= eop_n;
      stuff_q  <= stuff_n;
      line_q   <= line_n;
      rcving_q <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ones_n    = ones;
    prev_dp_n = prev_dp;
    d_orig_n  = d_orig_q;
    shift_n   = 1'b0;
    eop_n     = 1'b0;
    stuff_n   = 1'b0;
    line_n    = 1'b0;
    // NRZI: no transition between samples decodes as 1.
    bit_val   = ~(bus.d_plus ^ prev_dp);

    if (state == IDLE) begin
      if (edge_det && line_k) state_n = ACTIVE;
    end else begin
      if (edge_det || cnt == CNT_LAST) cnt_n = '0;
      else                             cnt_n = cnt + CNT_W'(1);

      if (strobe) begin
        case (state)
          ACTIVE: begin
            if (line_se0) begin
              state_n = SE0_1;
            end else begin
              prev_dp_n = bus.d_plus;
              if (ones == ONES_MAX) begin
                // Stuffed position: a 0 is silently dropped, a 1 is an error.
                ones_n  = '0;
                stuff_n = bit_val;
              end else begin
                shift_n  = 1'b1;
                d_orig_n = bit_val;
                ones_n   = bit_val ? ones + ONES_W'(1) : '0;
              end
            end
          end
          SE0_1: begin
            if (line_se0) begin
              state_n = SE0_2;
            end else begin
              line_n  = 1'b1;
              state_n = IDLE;
            end
          end
          SE0_2: begin
            // Extended SE0 simply keeps waiting for the closing J.
            if (!line_se0) begin
              if (line_k) line_n = 1'b1;
              else        eop_n  = 1'b1;
              state_n = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end

    // IDLE keeps the timing and decode history parked at their reset values.
    if (state_n == IDLE) begin
      cnt_n     = '0;
      ones_n    = '0;
      prev_dp_n = 1'b1;
    end
  end

  assign bus.d_orig       = d_orig_q;
  assign bus.shift_enable = shift_q;
  assign bus.eop          = eop_q;
  assign bus.stuff_error  = stuff_q;
  assign bus.line_error   = line_q;
  assign bus.rcving       = rcving_q;

endmodule
